fetch_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the MIPS pipeline. It generates the program counter and issues reads to a synchronous instruction memory with one-cycle latency. Returned words go into a prefetch FIFO of configurable depth, so fetch continues while ID is stalled. A taken branch flushes the FIFO, drops any in-flight response and redirects fetch. It replaces the single-entry fetch path and feeds the IF/ID boundary.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_prefetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FIFO entry layout, default widths and the level-width helper.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_PC_STEP = 4;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Bits needed to count 0..depth inclusive.
  function automatic int levelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: synchronous push/pop, single-cycle flush, level output and
// a combinational head. DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_INSTR_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = levelWidth(DEPTH)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] headData,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr_reg;
  logic [PTR_W-1:0] rdPtr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             doPush;
  logic             doPop;

  // Flush overrides both ports so a flushed cycle leaves the FIFO empty.
  assign doPush = push && !flush;
  assign doPop  = pop && !flush && (level_reg != '0);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr_reg <= '0;
      rdPtr_reg <= '0;
      level_reg <= '0;
    end else if (flush) begin
      wrPtr_reg <= '0;
      rdPtr_reg <= '0;
      level_reg <= '0;
    end else begin
      if (doPush) wrPtr_reg <= wrPtr_reg + PTR_W'(1);
      if (doPop)  rdPtr_reg <= rdPtr_reg + PTR_W'(1);
      level_reg <= level_reg + LVL_W'(doPush) - LVL_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr_reg] <= pushData;
  end

  assign headData = mem[rdPtr_reg];
  assign level    = level_reg;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch stage: PC generation, one-cycle-latency imem reads and a
// prefetch FIFO toward ID. Define FETCH_PERF_CNT_EN to add performance counters.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INSTR_W  = DEF_INSTR_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = DEF_PC_STEP,
  localparam int               LVL_W    = levelWidth(DEPTH)
) (
  input  logic               ClockInput,
  input  logic               ResetInputN,
  input  logic [ADDR_W-1:0]  BranchAddress,
  input  logic               BranchSelection,
  input  logic               IF_StallReq,
  output logic [ADDR_W-1:0]  ImemAddr,
  output logic               ImemRead,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  ProgramCounter,
  output logic               InstrValid,
  output logic [LVL_W-1:0]   FifoLevel
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        FetchCount,
  output logic [31:0]        StallCycles,
  output logic [31:0]        FlushCount
`endif
);

  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam int OCC_W   = LVL_W + 1;

  logic [ADDR_W-1:0]  fetchPc_reg, fetchPc_next;
  logic [ADDR_W-1:0]  inflightPc_reg, inflightPc_next;
  logic               inflightValid_reg, inflightValid_next;
  logic [LVL_W-1:0]   fifoLevel;
  logic [ENTRY_W-1:0] headEntry;
  logic               pop;
  logic               push;
  logic               issueOk;
  logic [OCC_W-1:0]   occupancy;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk      (ClockInput),
    .rstN     (ResetInputN),
    .flush    (BranchSelection),
    .push     (push),
    .pushData ({inflightPc_reg, ImemData}),
    .pop      (pop),
    .headData (headEntry),
    .level    (fifoLevel)
  );

  assign {ProgramCounter, Instruction} = headEntry;
  assign FifoLevel  = fifoLevel;
  assign InstrValid = (fifoLevel != '0) && !BranchSelection;
  assign pop        = InstrValid && !IF_StallReq;
  assign push       = inflightValid_reg && !BranchSelection;

  // Counting the in-flight read and crediting this cycle's pop keeps the
  // FIFO from overflowing while still allowing issue the cycle a stall drops.
  assign occupancy = OCC_W'(fifoLevel) + OCC_W'(inflightValid_reg) - OCC_W'(pop);
  assign issueOk   = occupancy < OCC_W'(DEPTH);

  always_comb begin
    ImemAddr           = fetchPc_reg;
    ImemRead           = 1'b0;
    fetchPc_next       = fetchPc_reg;
    inflightPc_next    = inflightPc_reg;
    inflightValid_next = 1'b0;
    if (BranchSelection) begin
      ImemAddr           = BranchAddress;
      ImemRead           = 1'b1;
      fetchPc_next       = BranchAddress + ADDR_W'(PC_STEP);
      inflightPc_next    = BranchAddress;
      inflightValid_next = 1'b1;
    end else if (issueOk) begin
      ImemRead           = 1'b1;
      fetchPc_next       = fetchPc_reg + ADDR_W'(PC_STEP);
      inflightPc_next    = fetchPc_reg;
      inflightValid_next = 1'b1;
    end
    // The read strobe must stay low for the whole time reset is asserted.
    if (!ResetInputN) begin
      ImemAddr = fetchPc_reg;
      ImemRead = 1'b0;
    end
  end

  always_ff @(posedge ClockInput or negedge ResetInputN) begin
    if (!ResetInputN) begin
      fetchPc_reg       <= RESET_PC;
      inflightPc_reg    <= RESET_PC;
      inflightValid_reg <= 1'b0;
    end else begin
      fetchPc_reg       <= fetchPc_next;
      inflightPc_reg    <= inflightPc_next;
      inflightValid_reg <= inflightValid_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [2:0] perfInc;
  assign perfInc = {BranchSelection, InstrValid && IF_StallReq, ImemRead};

  // Saturating event counters: 0 fetches, 1 stall cycles, 2 flushes.
  for (genvar gi = 0; gi < 3; gi++) begin : gPerf
    logic [31:0] cnt_reg;
    always_ff @(posedge ClockInput or negedge ResetInputN) begin
      if (!ResetInputN) begin
        cnt_reg <= '0;
      end else if (perfInc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  assign FetchCount  = gPerf[0].cnt_reg;
  assign StallCycles = gPerf[1].cnt_reg;
  assign FlushCount  = gPerf[2].cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed vector table, corner
// sequences, and a randomized run against an in-order program-stream model.
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rstN;
  logic [31:0]      branchAddress;
  logic             branchSel;
  logic             stallReq;
  logic [31:0]      imemAddr;
  logic             imemRead;
  logic [31:0]      imemData = '0;
  logic [31:0]      instruction;
  logic [31:0]      programCounter;
  logic             instrValid;
  logic [LVL_W-1:0] fifoLevel;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      fetchCount, stallCycles, flushCount;
`endif

  int total = 0;
  int bad   = 0;

  fetch_prefetch_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .PC_STEP  (4)
  ) dut (
    .ClockInput      (clk),
    .ResetInputN     (rstN),
    .BranchAddress   (branchAddress),
    .BranchSelection (branchSel),
    .IF_StallReq     (stallReq),
    .ImemAddr        (imemAddr),
    .ImemRead        (imemRead),
    .ImemData        (imemData),
    .Instruction     (instruction),
    .ProgramCounter  (programCounter),
    .InstrValid      (instrValid),
    .FifoLevel       (fifoLevel)
`ifdef FETCH_PERF_CNT_EN
    ,
    .FetchCount      (fetchCount),
    .StallCycles     (stallCycles),
    .FlushCount      (flushCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Synchronous instruction memory, one-cycle read latency.
  always @(posedge clk) begin
    if (imemRead) imemData <= instrOf(imemAddr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          stall;
    bit          br;
    logic [31:0] brAddr;
    bit          expValid;
    logic [31:0] expPc;
    int          expLevel;
    bit          expRead;
    logic [31:0] expAddr;
  } vec_t;

  vec_t vecs [26];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expPc;
    logic [31:0] tgt;
    int          sinceBr;
    bit          justBr;
    bit          st, br, got;

    // cycle index = cycles after reset release
    vecs[0]  = '{0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0};
    vecs[1]  = '{0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h4};
    vecs[2]  = '{0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h8};
    vecs[3]  = '{0, 0, 32'h0,        1, 32'h4,        1, 1, 32'hC};
    vecs[4]  = '{1, 0, 32'h0,        1, 32'h8,        1, 1, 32'h10};
    vecs[5]  = '{1, 0, 32'h0,        1, 32'h8,        2, 1, 32'h14};
    vecs[6]  = '{1, 0, 32'h0,        1, 32'h8,        3, 0, 32'h18};
    for (int i = 7; i <= 13; i++) vecs[i] = '{1, 0, 32'h0, 1, 32'h8, 4, 0, 32'h18};
    vecs[14] = '{0, 0, 32'h0,        1, 32'h8,        4, 1, 32'h18};
    vecs[15] = '{0, 0, 32'h0,        1, 32'hC,        3, 1, 32'h1C};
    vecs[16] = '{0, 0, 32'h0,        1, 32'h10,       3, 1, 32'h20};
    vecs[17] = '{0, 0, 32'h0,        1, 32'h14,       3, 1, 32'h24};
    vecs[18] = '{0, 1, 32'h100,      0, 32'h0,        3, 1, 32'h100};
    vecs[19] = '{0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h104};
    vecs[20] = '{0, 0, 32'h0,        1, 32'h100,      1, 1, 32'h108};
    vecs[21] = '{0, 0, 32'h0,        1, 32'h104,      1, 1, 32'h10C};
    vecs[22] = '{1, 1, 32'hFFFFFFFC, 0, 32'h0,        1, 1, 32'hFFFFFFFC};
    vecs[23] = '{0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0};
    vecs[24] = '{0, 0, 32'h0,        1, 32'hFFFFFFFC, 1, 1, 32'h4};
    vecs[25] = '{0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h8};

    // Reset state
    rstN = 1'b0; stallReq = 1'b0; branchSel = 1'b0; branchAddress = '0;
    @(negedge clk);
    check("resetValid", 64'(instrValid), 64'd0);
    check("resetLevel", 64'(fifoLevel), 64'd0);
    check("resetRead",  64'(imemRead), 64'd0);
    check("resetAddr",  64'(imemAddr), 64'h0);
    nextCycle();
    rstN = 1'b1;

    // Directed vector table
    for (int i = 0; i < 26; i++) begin
      stallReq = vecs[i].stall; branchSel = vecs[i].br; branchAddress = vecs[i].brAddr;
      @(negedge clk);
      check($sformatf("vec%0d.valid", i), 64'(instrValid), 64'(vecs[i].expValid));
      check($sformatf("vec%0d.level", i), 64'(fifoLevel), 64'(vecs[i].expLevel));
      check($sformatf("vec%0d.read", i),  64'(imemRead), 64'(vecs[i].expRead));
      check($sformatf("vec%0d.addr", i),  64'(imemAddr), 64'(vecs[i].expAddr));
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d.pc", i),    64'(programCounter), 64'(vecs[i].expPc));
        check($sformatf("vec%0d.instr", i), 64'(instruction), 64'(instrOf(vecs[i].expPc)));
      end
      $display("vec %0d: stall=%0b br=%0b valid=%0b pc=%08h level=%0d read=%0b addr=%08h",
               i, stallReq, branchSel, instrValid, programCounter, fifoLevel, imemRead, imemAddr);
      nextCycle();
    end

    // Branch together with stall while the FIFO is full
    branchSel = 1'b0; stallReq = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (fifoLevel == LVL_W'(DEPTH)) got = 1;
      else nextCycle();
    end
    check("fullReached", 64'(got), 64'd1);
    check("fullNoRead", 64'(imemRead), 64'd0);
    nextCycle();
    branchSel = 1'b1; branchAddress = 32'h200;
    @(negedge clk);
    check("brStall.valid", 64'(instrValid), 64'd0);
    check("brStall.read",  64'(imemRead), 64'd1);
    check("brStall.addr",  64'(imemAddr), 64'h200);
    nextCycle();
    branchSel = 1'b0;
    @(negedge clk);
    check("brStall.t1level", 64'(fifoLevel), 64'd0);
    check("brStall.t1valid", 64'(instrValid), 64'd0);
    nextCycle();
    @(negedge clk);
    check("brStall.t2valid", 64'(instrValid), 64'd1);
    check("brStall.t2pc",    64'(programCounter), 64'h200);
    check("brStall.t2instr", 64'(instruction), 64'(instrOf(32'h200)));
    $display("seq branch+stall: target pc=%08h valid=%0b", programCounter, instrValid);
    nextCycle();

    // Asynchronous reset mid-stream
    stallReq = 1'b0;
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("asyncRst.valid", 64'(instrValid), 64'd0);
    check("asyncRst.level", 64'(fifoLevel), 64'd0);
    check("asyncRst.read",  64'(imemRead), 64'd0);
    check("asyncRst.addr",  64'(imemAddr), 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check("asyncRst.fetchCount",  64'(fetchCount), 64'd0);
    check("asyncRst.stallCycles", 64'(stallCycles), 64'd0);
    check("asyncRst.flushCount",  64'(flushCount), 64'd0);
`endif
    nextCycle();
    rstN = 1'b1;
    @(negedge clk);
    check("restart.read", 64'(imemRead), 64'd1);
    check("restart.addr", 64'(imemAddr), 64'h0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    check("restart.valid", 64'(instrValid), 64'd1);
    check("restart.pc",    64'(programCounter), 64'h0);
    $display("seq async reset: restart pc=%08h valid=%0b", programCounter, instrValid);

    // Randomized run against the in-order stream model
    @(negedge clk);
    rstN = 1'b0;
    nextCycle();
    rstN = 1'b1;
    expPc = 32'h0; sinceBr = 0; justBr = 0;
    for (int c = 0; c < 600; c++) begin
      st = ($urandom_range(0, 99) < 35);
      br = ($urandom_range(0, 99) < 7);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC);
      stallReq = st; branchSel = br; branchAddress = tgt;
      @(negedge clk);
      if (br) begin
        check("rnd.brValid", 64'(instrValid), 64'd0);
        check("rnd.brRead",  64'(imemRead), 64'd1);
        check("rnd.brAddr",  64'(imemAddr), 64'(tgt));
      end else begin
        if (justBr) check("rnd.flushLevel", 64'(fifoLevel), 64'd0);
        check("rnd.valid", 64'(instrValid), 64'(sinceBr >= 2));
        if (sinceBr >= 2) begin
          check("rnd.pc",    64'(programCounter), 64'(expPc));
          check("rnd.instr", 64'(instruction), 64'(instrOf(expPc)));
        end
        check("rnd.levelBound", 64'(fifoLevel <= LVL_W'(DEPTH)), 64'd1);
      end
      if (br) begin
        expPc = tgt; sinceBr = 1; justBr = 1;
      end else begin
        if (sinceBr >= 2 && !st) begin
          $display("pop pc=%08h instr=%08h level=%0d", programCounter, instruction, fifoLevel);
          expPc = expPc + 32'd4;
        end
        sinceBr++; justBr = 0;
      end
      nextCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
